// File: rtl/ps2_key_proc.sv
// rtl/ps2_key_proc.sv - PS/2 keyboard frame receiver, make/break decoder and held-key tracker
// All outputs are registered so the downstream display stage can decode them combinationally.
module ps2_key_proc #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_num,
  output logic [7:0] asc_num,
  output logic [7:0] key_times,
  output logic       key_valid,
  output logic       frame_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HELD     = 2'd1;
  localparam logic [1:0] BRK_IDLE = 2'd2;
  localparam logic [1:0] BRK_HELD = 2'd3;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [2:0]  clk_sync_q;
  logic [1:0]  dat_sync_q;
  logic        fall_q, fall_d;
  logic [9:0]  frame_q, frame_d;
  logic [10:0] frame_w;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        byte_rdy_q, byte_rdy_d;
  logic [7:0]  byte_q, byte_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  key_num_q, key_num_d;
  logic [7:0]  asc_num_q, asc_num_d;
  logic [7:0]  key_times_q, key_times_d;
  logic        key_valid_q, key_valid_d;

  function automatic logic [7:0] ascii_of(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  assign fall_d  = clk_sync_q[2] & ~clk_sync_q[1];
  // frame_w is the frame including the bit arriving now; bit 0 is the oldest (start)
  assign frame_w = {dat_sync_q[1], frame_q};

  always_comb begin
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    byte_rdy_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    if (fall_q) begin
      frame_d  = frame_w[10:1];
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (!frame_w[0] && frame_w[10] && (^frame_w[9:1])) begin
          byte_rdy_d = 1'b1;
          byte_d     = frame_w[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_LAST) begin
        bit_cnt_d   = '0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    key_num_d   = key_num_q;
    asc_num_d   = asc_num_q;
    key_times_d = key_times_q;
    key_valid_d = key_valid_q;
    if (byte_rdy_q) begin
      case (state_q)
        IDLE: begin
          if (byte_q == 8'hF0) begin
            state_d = BRK_IDLE;
          end else if (byte_q != 8'hE0) begin
            key_num_d   = byte_q;
            asc_num_d   = ascii_of(byte_q);
            key_times_d = key_times_q + 8'd1;
            key_valid_d = 1'b1;
            state_d     = HELD;
          end
        end
        HELD: begin
          if (byte_q == 8'hF0) begin
            state_d = BRK_HELD;
          end else if (byte_q != 8'hE0 && byte_q != key_num_q) begin
            key_num_d   = byte_q;
            asc_num_d   = ascii_of(byte_q);
            key_times_d = key_times_q + 8'd1;
          end
        end
        BRK_HELD: begin
          if (byte_q == key_num_q) begin
            key_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 3'b111;
      dat_sync_q  <= 2'b11;
      fall_q      <= 1'b0;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      byte_rdy_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      state_q     <= IDLE;
      key_num_q   <= '0;
      asc_num_q   <= '0;
      key_times_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      fall_q      <= fall_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      byte_rdy_q  <= byte_rdy_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      key_num_q   <= key_num_d;
      asc_num_q   <= asc_num_d;
      key_times_q <= key_times_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_num   = key_num_q;
  assign asc_num   = asc_num_q;
  assign key_times = key_times_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_proc.sv
// tb/tb_ps2_key_proc.sv - directed bench for ps2_key_proc
// Drives PS/2 frames with an 8-cycle bit period and checks outputs after each frame.
module tb_ps2_key_proc;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_num, asc_num, key_times;
  logic       key_valid, frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int err_run = 0;
  int err_max = 0;

  ps2_key_proc #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_num(key_num), .asc_num(asc_num), .key_times(key_times),
    .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) begin
      err_cnt++;
      err_run++;
      if (err_run > err_max) err_max = err_run;
    end else begin
      err_run = 0;
    end
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    @(negedge clk);
    send_bits(f, 11);
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outs(input string name, input logic [7:0] k, input logic [7:0] a,
                            input logic [7:0] t, input logic v);
    if (key_num !== k) begin n_bad++; $display("FAIL %s key_num: got %h want %h", name, key_num, k); end
    n_cmp++;
    if (asc_num !== a) begin n_bad++; $display("FAIL %s asc_num: got %h want %h", name, asc_num, a); end
    n_cmp++;
    if (key_times !== t) begin n_bad++; $display("FAIL %s key_times: got %h want %h", name, key_times, t); end
    n_cmp++;
    if (key_valid !== v) begin n_bad++; $display("FAIL %s key_valid: got %b want %b", name, key_valid, v); end
    n_cmp++;
  endtask

  task automatic test_reset();
    apply_reset();
    check_outs("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
    n_cmp++;
  endtask

  task automatic test_typematic();
    apply_reset();
    send_frame(8'h1C);
    check_outs("make_1c", 8'h1C, 8'h61, 8'h01, 1'b1);
    send_frame(8'h1C);
    send_frame(8'h1C);
    send_frame(8'h1C);
    check_outs("typematic", 8'h1C, 8'h61, 8'h01, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h1C);
    check_outs("break_1c", 8'h1C, 8'h61, 8'h01, 1'b0);
    send_frame(8'hE0);
    check_outs("e0_idle", 8'h1C, 8'h61, 8'h01, 1'b0);
  endtask

  task automatic test_rollover();
    apply_reset();
    send_frame(8'h16);
    check_outs("make_16", 8'h16, 8'h31, 8'h01, 1'b1);
    send_frame(8'h1E);
    check_outs("roll_1e", 8'h1E, 8'h32, 8'h02, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h16);
    check_outs("brk_16", 8'h1E, 8'h32, 8'h02, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h1E);
    check_outs("brk_1e", 8'h1E, 8'h32, 8'h02, 1'b0);
  endtask

  task automatic test_errors();
    int e0;
    int c;
    bit seen;
    apply_reset();
    e0 = err_cnt;
    err_max = 0;
    send_frame(8'h1C, 1'b1);
    if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL parity_err count: got %0d want 1", err_cnt - e0); end
    n_cmp++;
    if (err_max !== 1) begin n_bad++; $display("FAIL parity_err width: got %0d want 1", err_max); end
    n_cmp++;
    check_outs("parity_err", 8'h00, 8'h00, 8'h00, 1'b0);
    // four complete bits, then the fifth falling edge and silence
    e0 = err_cnt;
    send_bits(11'b110_0011_1000, 4);
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    seen = 1'b0;
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 4) ps2_clk = 1'b1;
      if (frame_err) begin seen = 1'b1; c = i; break; end
    end
    if (!seen) begin n_bad++; $display("FAIL timeout: got no frame_err within 300 cycles want one"); end
    else if (c < 98 || c > 110) begin n_bad++; $display("FAIL timeout delay: got %0d want 98..110", c); end
    n_cmp++;
    repeat (4) @(negedge clk);
    if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout count: got %0d want 1", err_cnt - e0); end
    n_cmp++;
    check_outs("timeout", 8'h00, 8'h00, 8'h00, 1'b0);
    send_frame(8'h5A);
    check_outs("after_to_5a", 8'h5A, 8'h0D, 8'h01, 1'b1);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 255; i++) begin
      send_frame(8'h45);
      send_frame(8'hF0);
      send_frame(8'h45);
    end
    check_outs("wrap_255", 8'h45, 8'h30, 8'hFF, 1'b0);
    send_frame(8'h45);
    send_frame(8'hF0);
    send_frame(8'h45);
    check_outs("wrap_256", 8'h45, 8'h30, 8'h00, 1'b0);
    send_frame(8'h76);
    check_outs("unmapped_76", 8'h76, 8'h00, 8'h01, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    apply_reset();
    send_frame(8'h1C);
    check_outs("pre_mid_rst", 8'h1C, 8'h61, 8'h01, 1'b1);
    e0 = err_cnt;
    @(negedge clk);
    send_bits({1'b1, 1'b1, 8'h29, 1'b0}, 6);
    #2 rst = 1'b0;
    #1;
    check_outs("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h29);
    check_outs("after_rst_29", 8'h29, 8'h20, 8'h01, 1'b1);
    if (err_cnt !== e0) begin n_bad++; $display("FAIL mid_rst frame_err: got %0d pulses want 0", err_cnt - e0); end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_typematic();
    test_rollover();
    test_errors();
    test_wrap();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_proc.md
# ps2_key_proc

Receives PS/2 keyboard frames, decodes make/break sequences, and tracks the currently held key. Produces the scan code, its ASCII value and a press counter for the seven-segment display stage directly downstream. Registers every output, so the display stage can decode combinationally.

## Interface
- `TIMEOUT_CYC`, default 50000: number of `clk` cycles without a PS/2 falling edge, mid-frame, before the partial frame is discarded.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-low.
- `ps2_clk`  in  1  raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the keyboard, asynchronous.
- `key_num`  out  8  scan code of the last make code accepted.
- `asc_num`  out  8  ASCII value of `key_num`; `8'h00` if the code is unmapped.
- `key_times`  out  8  count of distinct key presses.
- `key_valid`  out  1  high while the key in `key_num` is held.
- `frame_err`  out  1  one-cycle pulse on a bad frame (start, parity or stop error) or on a timeout.

## Operation
- **Input sync.** Pass `ps2_clk` and `ps2_data` through 2-flop synchronizers. A third flop on `ps2_clk` detects its falling edge; this detection is a 1-cycle strobe `fall`.
- **Frame receiver.**
  - Shift `ps2_data` on each `fall` into an 11-bit frame, LSB first: start, d0..d7, parity, stop. A 4-bit counter counts 0..10.
  - After the 11th bit, the frame is good only if start==0, stop==1 and the XOR of d0..d7 and parity is 1 (odd parity).
  - Good frame: pulse internal `byte_rdy` with the data byte.
  - Bad frame: pulse `frame_err` and produce no byte.
  - In both cases the bit counter returns to 0.
- **Timeout.**
  - A 16-bit counter clears on every `fall` and increments while the bit counter is nonzero.
  - When it reaches `TIMEOUT_CYC`: bit counter goes to 0, `frame_err` pulses, and the partial frame is dropped.
  - The counter does not run while idle (bit counter == 0).
- **Decode FSM**, states IDLE, HELD, BRK_IDLE, BRK_HELD, acting on each `byte_rdy`:
  - IDLE, byte `F0`: go to BRK_IDLE.
  - IDLE, byte `E0`: ignore, stay in IDLE.
  - IDLE, any other byte (make code): `key_num`←byte, `asc_num`←map(byte), `key_times`++, `key_valid`←1, go to HELD.
  - HELD, byte `F0`: go to BRK_HELD.
  - HELD, byte `E0`: ignore.
  - HELD, byte == `key_num` (typematic repeat): no change.
  - HELD, other byte (rollover): update `key_num`/`asc_num`, `key_times`++, stay in HELD.
  - BRK_HELD, byte == `key_num`: `key_valid`←0, go to IDLE. `key_num` and `asc_num` are retained.
  - BRK_HELD, other byte: release of a non-tracked key; return to HELD with no output change.
  - BRK_IDLE, any byte: return to IDLE with no output change.
- **`key_times`** is 8-bit and wraps `8'hFF`→`8'h00`.
- **ASCII map**, combinational ROM:
  - A–Z → lowercase `8'h61`..`8'h7A`. Scan codes: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
  - 0–9 → `8'h30`..`8'h39`. Scan codes: 45,16,1E,26,25,2E,36,3D,3E,46.
  - `29`→`8'h20`; `5A`→`8'h0D`.
  - Any other code → `8'h00`.

## Timing
- Reset (`rst`=0): all outputs 0, FSM in IDLE, bit counter and timeout counter 0, synchronizer flops 1 (PS/2 idle-high).
- Reset asserted mid-frame discards the frame immediately. No `byte_rdy` or `frame_err` is emitted.
- Let E be the `clk` cycle in which `fall` marks the stop bit. Then:
  - `byte_rdy` or `frame_err` is high in cycle E+1.
  - `key_num`, `asc_num`, `key_times` and `key_valid` change at the clock edge ending cycle E+1, i.e. they are visible from E+2.
- `fall` lags the raw `ps2_clk` edge by 3 `clk` cycles.
- The receiver tolerates a `ps2_clk` period of at least 8 `clk` cycles.
- If `fall` and timeout expiry occur in the same cycle, `fall` wins: the counter clears and the bit is accepted.

## Test plan
- Send frame `1C` → from E+2: `key_num`=`1C`, `asc_num`=`61`, `key_times`=`01`, `key_valid`=1.
- Send `1C`,`1C`,`1C` (typematic), then `F0`,`1C` → `key_times` stays `01`. After the final byte, `key_valid`=0 while `key_num` stays `1C`.
- Send `16` then `1E` without a break (rollover), then `F0 16` → `key_num`=`1E`, `asc_num`=`32`, `key_times`=`02`, `key_valid` stays 1. Then `F0 1E` → `key_valid`=0.
- Send a frame with wrong parity for `1C` → `frame_err` is a 1-cycle pulse and all outputs are unchanged. Then stop after 5 bits with `TIMEOUT_CYC`=100 → `frame_err` pulses 100 cycles after the last `fall`. A following good `5A` gives `asc_num`=`0D`.
- Perform 256 press/release pairs of `45` → `key_times` wraps to `00`. Unmapped code `76` → `asc_num`=`00`.
- Assert `rst` after 6 bits of a frame → all outputs are 0 immediately. A full `29` frame after release gives `asc_num`=`20`, `key_times`=`01`.
